// File: rtl/vga_fb_pkg.sv
// Shared constants for the dual-page VGA framebuffer: loader opcodes,
// loader FSM states and the default 640x480-class timing.
package vga_fb_pkg;

    localparam logic [7:0] OP_SETADDR = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_SWAP    = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_SKIP
    } ld_state_t;

    // 256 visible clocks per line at 10 MHz covers the 640-pixel line time
    localparam int DEF_HVIS = 256;
    localparam int DEF_HFP  = 6;
    localparam int DEF_HSW  = 39;
    localparam int DEF_HBP  = 19;
    localparam int DEF_VVIS = 480;
    localparam int DEF_VFP  = 10;
    localparam int DEF_VSW  = 2;
    localparam int DEF_VBP  = 33;

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the VGA scan-out: hcnt/vcnt, raw active-low syncs,
// the visible flag, and a one-clk pulse on the first clk of vertical blanking
// (hcnt==0, vcnt==VVIS), which is where page flips are allowed to land.
module vga_timing #(
    parameter int HVIS = 256,
    parameter int HFP  = 6,
    parameter int HSW  = 39,
    parameter int HBP  = 19,
    parameter int VVIS = 480,
    parameter int VFP  = 10,
    parameter int VSW  = 2,
    parameter int VBP  = 33,
    localparam int HT  = HVIS + HFP + HSW + HBP,
    localparam int VT  = VVIS + VFP + VSW + VBP,
    localparam int HW  = $clog2(HT),
    localparam int VW  = $clog2(VT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync_pre,
    output logic          vsync_pre,
    output logic          visible,
    output logic          frame_start
);

    // Free-running raster position; vcnt advances when hcnt wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == HW'(HT - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == VW'(VT - 1)) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign hsync_pre   = !(hcnt >= HW'(HVIS + HFP) && hcnt < HW'(HVIS + HFP + HSW));
    assign vsync_pre   = !(vcnt >= VW'(VVIS + VFP) && vcnt < VW'(VVIS + VFP + VSW));
    assign visible     = (hcnt < HW'(HVIS)) && (vcnt < VW'(VVIS));
    assign frame_start = (hcnt == '0) && (vcnt == VW'(VVIS));

endmodule

// File: rtl/vga_fb_dualpage.sv
// Dual-page VGA framebuffer: scans the front page out of a 1R/1W memory
// (read latency 1) while a serial loader writes the back page. Page flips
// requested by the loader are deferred to the start of vertical blanking.
module vga_fb_dualpage
    import vga_fb_pkg::*;
#(
    parameter int HVIS   = DEF_HVIS,
    parameter int HFP    = DEF_HFP,
    parameter int HSW    = DEF_HSW,
    parameter int HBP    = DEF_HBP,
    parameter int VVIS   = DEF_VVIS,
    parameter int VFP    = DEF_VFP,
    parameter int VSW    = DEF_VSW,
    parameter int VBP    = DEF_VBP,
    parameter int PIX_W  = 3,
    parameter int FB_LW  = 7,
    parameter int FB_LH  = 7,
    parameter int X0     = 64,
    parameter int Y0     = 0,
    parameter int YSHIFT = 1,
    localparam int AW    = FB_LW + FB_LH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_clk,
    input  logic             serial_data,
    input  logic             serial_cs_n,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [PIX_W-1:0] mem_rd_data,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [PIX_W-1:0] mem_wr_data,
    output logic             mem_wr_en,
    output logic             hsync,
    output logic             vsync,
    output logic [PIX_W-1:0] rgb,
    output logic             swap_pending
);

    localparam int HT   = HVIS + HFP + HSW + HBP;
    localparam int VT   = VVIS + VFP + VSW + VBP;
    localparam int HW   = $clog2(HT);
    localparam int VW   = $clog2(VT);
    localparam int PW   = FB_LW + FB_LH;
    localparam int FB_W = 1 << FB_LW;
    localparam int FB_H = 1 << FB_LH;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hsync_pre, vsync_pre, visible, frame_start;

    vga_timing #(
        .HVIS(HVIS), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VBP(VBP)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hsync_pre  (hsync_pre),
        .vsync_pre  (vsync_pre),
        .visible    (visible),
        .frame_start(frame_start)
    );

    // ---------------- scan-out ----------------
    logic             front_page;
    int               hrel, vrel;
    logic             in_win;
    logic [FB_LH-1:0] row;
    logic [FB_LW-1:0] col;

    // Map the raster position into framebuffer coordinates; signed math so
    // positions left of / above the window fall out as negative
    always_comb begin
        hrel   = int'(hcnt) - X0;
        vrel   = (int'(vcnt) - Y0) >>> YSHIFT;
        in_win = visible && (hrel >= 0) && (hrel < FB_W) && (vrel >= 0) && (vrel < FB_H);
    end

    assign row         = vrel[FB_LH-1:0];
    assign col         = hrel[FB_LW-1:0];
    assign mem_rd_addr = {front_page, row, col};

    logic win_d1, hs_d1, vs_d1;

    // Two-stage output pipe: address goes out with the counters, data comes
    // back a clk later, then pixel and syncs are registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            rgb    <= '0;
        end else begin
            win_d1 <= in_win;
            hs_d1  <= hsync_pre;
            vs_d1  <= vsync_pre;
            hsync  <= hs_d1;
            vsync  <= vs_d1;
            rgb    <= win_d1 ? mem_rd_data : '0;
        end
    end

    // ---------------- serial loader ----------------
    logic [1:0] sclk_sync, sdat_sync, scs_sync;
    logic       sclk_q;
    logic       sclk_edge, sdat, cs_n_s;

    // 2-FF synchronisers for the loader pins, plus one more flop on the
    // serial clock so both of its edges can be detected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            sdat_sync <= 2'b00;
            scs_sync  <= 2'b11;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], serial_clk};
            sdat_sync <= {sdat_sync[0], serial_data};
            scs_sync  <= {scs_sync[0], serial_cs_n};
            sclk_q    <= sclk_sync[1];
        end
    end

    assign sclk_edge = sclk_sync[1] ^ sclk_q;
    assign sdat      = sdat_sync[1];
    assign cs_n_s    = scs_sync[1];

    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       byte_go;

    // Bit assembly, MSB first; deselect drops any partial byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            byte_go <= 1'b0;
        end else begin
            byte_go <= 1'b0;
            if (cs_n_s) begin
                bit_cnt <= '0;
            end else if (sclk_edge) begin
                shreg   <= {shreg[6:0], sdat};
                bit_cnt <= bit_cnt + 1'b1;
                byte_go <= (bit_cnt == 3'd7);
            end
        end
    end

    ld_state_t       state;
    logic [7:0]      addr_hi;
    logic [PW-1:0]   wr_ptr;

    // Loader FSM with write strobe, pointer and page-flip bookkeeping.
    // A swap request landing on the flip clk is written last, so it stays
    // pending for the next frame instead of being lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            addr_hi      <= '0;
            wr_ptr       <= '0;
            mem_wr_en    <= 1'b0;
            mem_wr_data  <= '0;
            swap_pending <= 1'b0;
            front_page   <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            if (mem_wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (frame_start && swap_pending) begin
                front_page   <= ~front_page;
                swap_pending <= 1'b0;
            end
            if (cs_n_s) begin
                state <= ST_IDLE;
            end else if (byte_go) begin
                case (state)
                    ST_IDLE: begin
                        case (shreg)
                            OP_SETADDR: state <= ST_ADDR_HI;
                            OP_WRITE:   state <= ST_DATA;
                            OP_SWAP:    swap_pending <= 1'b1;
                            default:    state <= ST_SKIP;
                        endcase
                    end
                    ST_ADDR_HI: begin
                        addr_hi <= shreg;
                        state   <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        wr_ptr <= PW'({addr_hi, shreg});
                        state  <= ST_IDLE;
                    end
                    ST_DATA: begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= shreg[PIX_W-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Writes always go to the page not on screen
    assign mem_wr_addr = {~front_page, wr_ptr};

endmodule

// File: tb/tb_vga_fb_dualpage.sv
// Directed bench for vga_fb_dualpage. Horizontal timing is the default;
// vertical timing is shortened (16/2/2/3 lines) so a frame is 320*23 clks.
module tb_vga_fb_dualpage;

    localparam int HT = 320;
    localparam int VT = 23;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_clk = 1'b0;
    logic        serial_data = 1'b0;
    logic        serial_cs_n = 1'b1;
    logic [14:0] mem_rd_addr, mem_wr_addr;
    logic [2:0]  mem_rd_data, mem_wr_data, rgb;
    logic        mem_wr_en, hsync, vsync, swap_pending;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    logic [2:0]  mem [0:32767];
    logic [14:0] wa_q[$];
    logic [2:0]  wd_q[$];

    vga_fb_dualpage #(.VVIS(16), .VFP(2), .VSW(2), .VBP(3)) dut (
        .clk(clk), .reset(reset),
        .serial_clk(serial_clk), .serial_data(serial_data), .serial_cs_n(serial_cs_n),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .swap_pending(swap_pending)
    );

    always #5 clk = ~clk;

    // cyc equals the DUT hcnt+vcnt*HT position during the cycle it names
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0; else cyc <= cyc + 1;

    // memory model with one-clk read latency, plus a write log
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_rd_addr];
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (!reset && mem_wr_en) begin
            wa_q.push_back(mem_wr_addr);
            wd_q.push_back(mem_wr_data);
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
        if (cyc != t) begin
            n_chk++; n_fail++;
            $display("FAIL sched: at cyc %0d, wanted %0d", cyc, t);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            serial_data = b[7-i];
            repeat (3) @(negedge clk);
            serial_clk = ~serial_clk;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic cs_lo();
        serial_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (10) @(negedge clk);
        serial_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got %b%b want 11", hsync, vsync); end
        n_chk++; if (rgb !== 3'd0) begin n_fail++; $display("FAIL reset_rgb: got %0d want 0", rgb); end
        n_chk++; if (mem_wr_en !== 1'b0 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: wr_en %b pend %b want 0 0", mem_wr_en, swap_pending); end
        n_chk++; if (mem_wr_addr !== 15'h4000) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 4000", mem_wr_addr); end
        n_chk++; if (mem_rd_addr[14] !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %b want 0", mem_rd_addr[14]); end
        reset = 1'b0;
    endtask

    task automatic test_timing();
        int hlo = 0, vlo = 0, fall1 = -1, rise1 = -1, fall2 = -1;
        logic vprev = 1'b1;
        for (int i = 2; i <= 13122; i++) begin
            wait_cyc(i);
            if (i < 322 && !hsync) hlo++;
            if (i == 263 || i == 264 || i == 302 || i == 303) begin
                n_chk++;
                if (hsync !== ((i == 263 || i == 303) ? 1'b1 : 1'b0)) begin
                    n_fail++; $display("FAIL hsync_edge: cyc %0d got %b", i, hsync);
                end
            end
            if (i < FT + 2 && !vsync) vlo++;
            if (vprev && !vsync) begin if (fall1 < 0) fall1 = i; else fall2 = i; end
            if (!vprev && vsync && rise1 < 0) rise1 = i;
            vprev = vsync;
        end
        n_chk++; if (hlo != 39) begin n_fail++; $display("FAIL hsync_width: got %0d want 39", hlo); end
        n_chk++; if (vlo != 640) begin n_fail++; $display("FAIL vsync_width: got %0d want 640", vlo); end
        n_chk++; if (fall1 != 18*HT + 2 || rise1 != 20*HT + 2) begin n_fail++; $display("FAIL vsync_lines: fall %0d rise %0d want %0d %0d", fall1, rise1, 18*HT+2, 20*HT+2); end
        n_chk++; if (fall2 - fall1 != FT) begin n_fail++; $display("FAIL frame_period: got %0d want %0d", fall2 - fall1, FT); end
    endtask

    task automatic test_window();
        int f = 2 * FT;
        logic [2:0] exp;
        for (int v = 0; v < 2; v++)
            for (int h = 60; h < 196; h++) begin
                wait_cyc(f + v*HT + h + 2);
                exp = (h >= 64 && h < 192) ? 3'(h - 64) : 3'd0;
                n_chk++;
                if (rgb !== exp) begin n_fail++; $display("FAIL window_pix: h %0d v %0d got %0d want %0d", h, v, rgb, exp); end
            end
        wait_cyc(f + 15*HT + 72);
        n_chk++; if (rgb !== 3'd6) begin n_fail++; $display("FAIL window_last_line: got %0d want 6", rgb); end
        wait_cyc(f + 16*HT + 72);
        n_chk++; if (rgb !== 3'd0) begin n_fail++; $display("FAIL vblank_rgb: got %0d want 0", rgb); end
    endtask

    task automatic check_writes(input string nm, input logic [14:0] a0, input logic [2:0] d0,
                                input logic [14:0] a1, input logic [2:0] d1, input int n);
        n_chk++;
        if (wa_q.size() != n) begin
            n_fail++; $display("FAIL %s_count: got %0d want %0d", nm, wa_q.size(), n);
        end else begin
            if (wa_q[0] !== a0 || wd_q[0] !== d0) begin n_fail++; $display("FAIL %s_w0: got %h/%b want %h/%b", nm, wa_q[0], wd_q[0], a0, d0); end
            if (n > 1 && (wa_q[1] !== a1 || wd_q[1] !== d1)) begin n_fail++; $display("FAIL %s_w1: got %h/%b want %h/%b", nm, wa_q[1], wd_q[1], a1, d1); end
        end
        wa_q.delete(); wd_q.delete();
    endtask

    task automatic test_load();
        wa_q.delete(); wd_q.delete();
        cs_lo();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        cs_hi();
        check_writes("load", 15'h4005, 3'b010, 15'h4006, 3'b011, 2);
        n_chk++; if (mem_wr_addr !== 15'h4007) begin n_fail++; $display("FAIL load_ptr: got %h want 4007", mem_wr_addr); end
    endtask

    task automatic test_wrap();
        cs_lo();
        send_byte(8'h01); send_byte(8'h3F); send_byte(8'hFF);
        send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        cs_hi();
        check_writes("wrap", 15'h7FFF, 3'b001, 15'h4000, 3'b010, 2);
    endtask

    function automatic int next_flip(input int now);
        int c = (now / FT) * FT + 16*HT;
        if (c <= now) c += FT;
        return c;
    endfunction

    task automatic test_swap();
        int c;
        cs_lo(); send_byte(8'h03); cs_hi();
        n_chk++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL swap_req: pend got %b want 1", swap_pending); end
        c = next_flip(cyc);
        wait_cyc(c);
        n_chk++; if (swap_pending !== 1'b1 || mem_rd_addr[14] !== 1'b0) begin n_fail++; $display("FAIL swap_hold: pend %b front %b want 1 0", swap_pending, mem_rd_addr[14]); end
        wait_cyc(c + 1);
        n_chk++; if (swap_pending !== 1'b0 || mem_rd_addr[14] !== 1'b1 || mem_wr_addr[14] !== 1'b0) begin
            n_fail++; $display("FAIL swap_apply: pend %b front %b back %b want 0 1 0", swap_pending, mem_rd_addr[14], mem_wr_addr[14]);
        end
        cs_lo(); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); cs_hi();
        cs_lo(); send_byte(8'h02); send_byte(8'h55); cs_hi();
        check_writes("swap_wr", 15'h0010, 3'b101, 15'h0000, 3'b000, 1);
        cs_lo(); send_byte(8'h03); send_byte(8'h03); cs_hi();
        c = next_flip(cyc);
        wait_cyc(c + 1);
        n_chk++; if (swap_pending !== 1'b0 || mem_rd_addr[14] !== 1'b0) begin n_fail++; $display("FAIL swap_twice: pend %b front %b want 0 0", swap_pending, mem_rd_addr[14]); end
        wait_cyc(c + FT + 1);
        n_chk++; if (mem_rd_addr[14] !== 1'b0) begin n_fail++; $display("FAIL swap_once: front %b want 0", mem_rd_addr[14]); end
    endtask

    task automatic test_partial();
        cs_lo(); send_bits(8'hFF, 5); cs_hi();
        cs_lo(); send_byte(8'h02); send_byte(8'h11); cs_hi();
        check_writes("partial", 15'h4011, 3'b001, 15'h0000, 3'b000, 1);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        cs_lo();
        send_byte(8'h03); send_byte(8'h02); send_bits(8'h77, 7);
        serial_data = 1'b1;
        repeat (3) @(negedge clk);
        serial_clk = ~serial_clk;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_wr_en;
        end
        n_chk++; if (!seen || swap_pending !== 1'b1) begin n_fail++; $display("FAIL midburst_setup: wr_en seen %b pend %b want 1 1", seen, swap_pending); end
        #1 reset = 1'b1;
        #1;
        n_chk++; if (mem_wr_en !== 1'b0 || mem_wr_addr !== 15'h4000) begin n_fail++; $display("FAIL midburst_reset: wr_en %b addr %h want 0 4000", mem_wr_en, mem_wr_addr); end
        n_chk++; if (swap_pending !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 3'd0) begin
            n_fail++; $display("FAIL midburst_outs: pend %b hs %b vs %b rgb %0d want 0 1 1 0", swap_pending, hsync, vsync, rgb);
        end
        serial_cs_n = 1'b1; serial_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_cyc(263);
        n_chk++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL restart_hs263: got %b want 1", hsync); end
        wait_cyc(264);
        n_chk++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL restart_hs264: got %b want 0", hsync); end
        wa_q.delete(); wd_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]         = i[2:0];
            mem[16384 + i] = 3'(~i);
        end
        test_reset();
        test_timing();
        test_window();
        test_load();
        test_wrap();
        test_swap();
        test_partial();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
